// File: rtl/ad5621_interface.sv
`default_nettype none
// ============================================================================
// Module   : ad5621_interface
// Purpose  : Write-only SPI master for an AD5621-class 12-bit voltage-output
//            DAC. One 12-bit code plus a 2-bit power-down mode is accepted
//            through a valid/ready handshake and sent as a 16-bit,
//            SYNC_n-framed word {pd_mode, data, 2'b00}, MSB first. SDIN
//            changes with the SCLK rising edge. The DAC samples SDIN on the
//            SCLK falling edge.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_i      in   1   system clock, rising edge
//   rst_i      in   1   synchronous active-high reset
//   valid_i    in   1   write request
//   ready_o    out  1   idle; a request is accepted this cycle
//   data_i     in  12   DAC code, MSB first on the wire
//   pd_mode_i  in   2   power-down bits PD1:PD0 (00 = normal)
//   done_o     out  1   one-cycle pulse at the end of frame + SYNC high time
//   sclk_o     out  1   SPI clock, idles high
//   sync_n_o   out  1   active-low frame sync
//   sdin_o     out  1   serial data to the DAC
// ============================================================================
module ad5621_interface #(
   parameter int CLK_FREQ_HZ       = 100_000_000,
   parameter int SCLK_FREQ_HZ      = 25_000_000,
   parameter int SYNC_SETUP_CYCLES = 2,
   parameter int SYNC_HIGH_CYCLES  = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [11:0] data_i,
   input  logic [1:0]  pd_mode_i,
   output logic        done_o,
   output logic        sclk_o,
   output logic        sync_n_o,
   output logic        sdin_o
);

   // ------------------------------------------------------------------------
   // Derived constants
   // ------------------------------------------------------------------------
   localparam int c_clk_div  = CLK_FREQ_HZ / SCLK_FREQ_HZ;
   localparam int c_half     = c_clk_div / 2;
   localparam int c_ph_max_a = (c_half > SYNC_SETUP_CYCLES) ? c_half : SYNC_SETUP_CYCLES;
   localparam int c_ph_max   = (c_ph_max_a > SYNC_HIGH_CYCLES) ? c_ph_max_a : SYNC_HIGH_CYCLES;
   localparam int c_ph_w     = $clog2(c_ph_max + 1);

   // Reload values for the down-counting phase counter (count N-1 .. 0).
   localparam logic [c_ph_w-1:0] c_half_load  = c_ph_w'(c_half - 1);
   localparam logic [c_ph_w-1:0] c_setup_load = c_ph_w'(SYNC_SETUP_CYCLES - 1);
   localparam logic [c_ph_w-1:0] c_gap_load   = c_ph_w'(SYNC_HIGH_CYCLES - 1);
   localparam logic [c_ph_w-1:0] c_ph_one     = c_ph_w'(1);
   localparam logic [c_ph_w-1:0] c_ph_zero    = '0;

   // With a one-cycle gap the first GAP cycle is also the last one.
   localparam logic c_gap_single = (SYNC_HIGH_CYCLES == 1);

   // ------------------------------------------------------------------------
   // Elaboration guards
   // ------------------------------------------------------------------------
   generate
      if (SCLK_FREQ_HZ > 30_000_000) begin : g_err_sclk_fast
         $error("ad5621_interface: SCLK_FREQ_HZ exceeds 30 MHz");
      end
      if (c_clk_div < 2) begin : g_err_div_small
         $error("ad5621_interface: CLK_FREQ_HZ / SCLK_FREQ_HZ must be >= 2");
      end
      if ((c_clk_div % 2) != 0) begin : g_err_div_odd
         $error("ad5621_interface: CLK_FREQ_HZ / SCLK_FREQ_HZ must be even");
      end
      if (SYNC_SETUP_CYCLES < 1) begin : g_err_setup
         $error("ad5621_interface: SYNC_SETUP_CYCLES must be >= 1");
      end
      if (SYNC_HIGH_CYCLES < 1) begin : g_err_high
         $error("ad5621_interface: SYNC_HIGH_CYCLES must be >= 1");
      end
   endgenerate

   // ------------------------------------------------------------------------
   // State machine
   // ------------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   state_t              r_state;
   logic [c_ph_w-1:0]   r_phase;     // cycles left in current phase, minus one
   logic [3:0]          r_bit_cnt;   // SCLK falling edges issued, modulo 16
   logic                r_bit_term;  // set on the 16th falling edge
   logic [14:0]         r_shift;     // remaining bits; bit 15 goes straight to SDIN
   logic                r_ready;
   logic                r_done;
   logic                r_sclk;
   logic                r_sync_n;
   logic                r_sdin;

   logic [15:0]         w_frame;

   assign w_frame = {pd_mode_i, data_i, 2'b00};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= ST_IDLE;
         r_phase    <= c_ph_zero;
         r_bit_cnt  <= 4'd0;
         r_bit_term <= 1'b0;
         r_shift    <= 15'd0;
         r_ready    <= 1'b1;
         r_done     <= 1'b0;
         r_sclk     <= 1'b1;
         r_sync_n   <= 1'b1;
         r_sdin     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (valid_i) begin
                  // Inputs are captured here; they may change afterwards.
                  r_state    <= ST_SETUP;
                  r_phase    <= c_setup_load;
                  r_bit_cnt  <= 4'd0;
                  r_bit_term <= 1'b0;
                  r_shift    <= w_frame[14:0];
                  r_sdin     <= w_frame[15];
                  r_sync_n   <= 1'b0;
                  r_sclk     <= 1'b1;
                  r_ready    <= 1'b0;
               end
            end

            ST_SETUP: begin
               // SCLK is already high, so SHIFT starts directly with the
               // high half of the first bit period.
               if (r_phase == c_ph_zero) begin
                  r_state <= ST_SHIFT;
                  r_phase <= c_half_load;
               end else begin
                  r_phase <= r_phase - c_ph_one;
               end
            end

            ST_SHIFT: begin
               if (r_phase != c_ph_zero) begin
                  r_phase <= r_phase - c_ph_one;
               end else if (r_sclk) begin
                  // End of high half: falling edge, DAC samples SDIN.
                  r_sclk  <= 1'b0;
                  r_phase <= c_half_load;
                  if (r_bit_cnt == 4'hF) begin
                     r_bit_cnt  <= 4'd0;
                     r_bit_term <= 1'b1;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end
               end else begin
                  // End of low half: SCLK rises.
                  r_sclk <= 1'b1;
                  if (r_bit_term) begin
                     r_state  <= ST_GAP;
                     r_phase  <= c_gap_load;
                     r_sync_n <= 1'b1;
                     r_sdin   <= 1'b0;
                     r_done   <= c_gap_single;
                  end else begin
                     // Next bit goes out together with the rising edge.
                     r_phase <= c_half_load;
                     r_sdin  <= r_shift[14];
                     r_shift <= {r_shift[13:0], 1'b0};
                  end
               end
            end

            ST_GAP: begin
               if (r_phase == c_ph_zero) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b0;
                  r_ready <= 1'b1;
               end else begin
                  r_phase <= r_phase - c_ph_one;
                  r_done  <= (r_phase == c_ph_one);
               end
            end

            default: begin
               r_state  <= ST_IDLE;
               r_ready  <= 1'b1;
               r_done   <= 1'b0;
               r_sclk   <= 1'b1;
               r_sync_n <= 1'b1;
               r_sdin   <= 1'b0;
            end
         endcase
      end
   end

   assign ready_o  = r_ready;
   assign done_o   = r_done;
   assign sclk_o   = r_sclk;
   assign sync_n_o = r_sync_n;
   assign sdin_o   = r_sdin;

endmodule
`default_nettype wire

// File: tb/tb_ad5621_interface.sv
`default_nettype none
// ============================================================================
// Module   : tb_ad5621_interface
// Purpose  : Self-checking bench for ad5621_interface. Expected waveforms are
//            computed per cycle from the frame timing rules (setup, 16 bit
//            periods of CLK_DIV cycles, gap) and the frame word
//            {pd_mode, data, 2'b00}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ad5621_interface;

   localparam int CLK_FREQ_HZ       = 100_000_000;
   localparam int SCLK_FREQ_HZ      = 25_000_000;
   localparam int SYNC_SETUP_CYCLES = 2;
   localparam int SYNC_HIGH_CYCLES  = 4;

   localparam int D      = CLK_FREQ_HZ / SCLK_FREQ_HZ;
   localparam int H      = D / 2;
   localparam int S      = SYNC_SETUP_CYCLES;
   localparam int G      = SYNC_HIGH_CYCLES;
   localparam int LOWEND = S + 16 * D;       // last cycle with SYNC_n low
   localparam int NCYC   = LOWEND + G + 1;   // cycle where ready returns

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [11:0] data_i = 12'd0;
   logic [1:0]  pd_mode_i = 2'd0;
   logic        done_o;
   logic        sclk_o;
   logic        sync_n_o;
   logic        sdin_o;

   int n_checks = 0;
   int n_errors = 0;

   ad5621_interface #(
      .CLK_FREQ_HZ       (CLK_FREQ_HZ),
      .SCLK_FREQ_HZ      (SCLK_FREQ_HZ),
      .SYNC_SETUP_CYCLES (SYNC_SETUP_CYCLES),
      .SYNC_HIGH_CYCLES  (SYNC_HIGH_CYCLES)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .data_i    (data_i),
      .pd_mode_i (pd_mode_i),
      .done_o    (done_o),
      .sclk_o    (sclk_o),
      .sync_n_o  (sync_n_o),
      .sdin_o    (sdin_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] frame_word(input logic [11:0] d, input logic [1:0] p);
      return {p, d, 2'b00};
   endfunction

   // Waits (bounded) for ready at a falling edge, presents the request and
   // returns just after the accepting rising edge (spec cycle 0).
   task automatic start_frame(input logic [11:0] d, input logic [1:0] p,
                              input bit hold, output bit ok);
      int n;
      ok = 1'b0;
      n  = 0;
      @(negedge clk);
      while (!ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!ready_o) begin
         chk("ready_timeout", 32'(ready_o), 32'd1);
         return;
      end
      data_i    = d;
      pd_mode_i = p;
      valid_i   = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) begin
         valid_i   = 1'b0;
         data_i    = 12'($urandom);
         pd_mode_i = 2'($urandom);
      end
      ok = 1'b1;
   endtask

   // Observes cycles 1..NCYC after acceptance and compares every output with
   // the timing model. mode 0: random valid noise, 1: valid held high,
   // 2: valid pulses at cycles 10 and 40.
   task automatic run_frame(input logic [15:0] word, input int mode, input string tag);
      int sclk_err = 0, sdin_err = 0, sync_err = 0, ready_err = 0;
      int done_cnt = 0, done_at = -1, falls = 0, spacing_err = 0;
      int last_fall = -1, high_cnt = 0, t;
      logic [15:0] samp = 16'd0;
      logic prev_sclk = 1'b1;
      logic e_sclk, e_sdin, e_sync, e_ready;
      for (int k = 1; k <= NCYC; k++) begin
         @(negedge clk);
         if (k <= S) begin
            e_sclk = 1'b1;
            e_sdin = word[15];
         end else if (k <= LOWEND) begin
            t      = k - S - 1;
            e_sclk = ((t % D) < H);
            e_sdin = word[15 - t / D];
         end else begin
            e_sclk = 1'b0 | 1'b1;
            e_sdin = 1'b0;
         end
         e_sync  = (k > LOWEND);
         e_ready = (k == NCYC);
         if (sclk_o !== e_sclk)    sclk_err++;
         if (sdin_o !== e_sdin)    sdin_err++;
         if (sync_n_o !== e_sync)  sync_err++;
         if (ready_o !== e_ready)  ready_err++;
         if (done_o) begin
            done_cnt++;
            done_at = k;
         end
         if (!sync_n_o && prev_sclk && !sclk_o) begin
            falls++;
            samp = {samp[14:0], sdin_o};
            if (last_fall >= 0 && (k - last_fall) != D) spacing_err++;
            last_fall = k;
         end
         if (k > LOWEND && sync_n_o) high_cnt++;
         prev_sclk = sclk_o;
         case (mode)
            1: valid_i = 1'b1;
            2: valid_i = (k == 10 || k == 40);
            default: begin
               valid_i   = (k < NCYC) ? 1'($urandom) : 1'b0;
               data_i    = 12'($urandom);
               pd_mode_i = 2'($urandom);
            end
         endcase
      end
      chk({tag, "_word"},        32'(samp),        32'(word));
      chk({tag, "_falls"},       32'(falls),       32'd16);
      chk({tag, "_fall_space"},  32'(spacing_err), 32'd0);
      chk({tag, "_sclk_seq"},    32'(sclk_err),    32'd0);
      chk({tag, "_sdin_seq"},    32'(sdin_err),    32'd0);
      chk({tag, "_sync_seq"},    32'(sync_err),    32'd0);
      chk({tag, "_ready_seq"},   32'(ready_err),   32'd0);
      chk({tag, "_done_cnt"},    32'(done_cnt),    32'd1);
      chk({tag, "_done_at"},     32'(done_at),     32'(LOWEND + G));
      chk({tag, "_sync_high"},   32'(high_cnt),    32'(G + 1));
   endtask

   initial begin
      bit ok;
      logic [11:0] d;
      logic [1:0]  p;
      logic [15:0] w2;
      int falls, dones, exp_falls;
      logic prev;

      // Reset held together with valid: reset must win.
      rst_i   = 1'b1;
      valid_i = 1'b1;
      data_i  = 12'hABC;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", 32'({ready_o, done_o, sclk_o, sync_n_o, sdin_o}), 32'b10110);
      rst_i   = 1'b0;
      valid_i = 1'b0;
      @(negedge clk);
      chk("idle_outs", 32'({ready_o, done_o, sclk_o, sync_n_o, sdin_o}), 32'b10110);

      // Directed words.
      start_frame(12'hABC, 2'b00, 1'b0, ok);
      if (ok) run_frame(16'h2AF0, 0, "abc");
      start_frame(12'hFFF, 2'b11, 1'b0, ok);
      if (ok) run_frame(16'hFFFC, 0, "fff");
      start_frame(12'h000, 2'b00, 1'b0, ok);
      if (ok) run_frame(16'h0000, 0, "zero");

      // Back-to-back with valid held high.
      d  = 12'($urandom);
      p  = 2'($urandom);
      start_frame(d, p, 1'b1, ok);
      if (ok) begin
         data_i    = 12'h5A3;
         pd_mode_i = 2'b10;
         w2        = frame_word(12'h5A3, 2'b10);
         run_frame(frame_word(d, p), 1, "b2b_a");
         @(posedge clk);
         #1;
         valid_i   = 1'b0;
         run_frame(w2, 0, "b2b_b");
      end

      // Valid pulses mid-frame are ignored, nothing follows.
      start_frame(12'h3C5, 2'b01, 1'b0, ok);
      if (ok) begin
         run_frame(frame_word(12'h3C5, 2'b01), 2, "pulse");
         dones = 0;
         falls = 0;
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done_o) dones++;
            if (!sync_n_o || !ready_o) falls++;
         end
         chk("pulse_no_second_done", 32'(dones), 32'd0);
         chk("pulse_no_second_frame", 32'(falls), 32'd0);
      end

      // Reset in the middle of a frame (rst sampled at cycle 30).
      d = 12'($urandom);
      p = 2'($urandom);
      start_frame(d, p, 1'b0, ok);
      if (ok) begin
         falls = 0;
         dones = 0;
         exp_falls = 0;
         prev = 1'b1;
         for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            if (k <= 30) begin
               if (!sync_n_o && prev && !sclk_o) falls++;
               if (done_o) dones++;
               if (k > S && k <= LOWEND && ((k - S - 1) % D) == H) exp_falls++;
               prev = sclk_o;
            end
            if (k == 30) rst_i = 1'b1;
            if (k == 31) begin
               chk("abort_outs", 32'({ready_o, done_o, sclk_o, sync_n_o, sdin_o}), 32'b10110);
               rst_i = 1'b0;
            end
         end
         chk("abort_falls", 32'(falls), 32'(exp_falls));
         chk("abort_no_done", 32'(dones), 32'd0);
         start_frame(12'h9E1, 2'b00, 1'b0, ok);
         if (ok) run_frame(frame_word(12'h9E1, 2'b00), 0, "after_abort");
      end

      // Reset and valid together while idle: nothing is accepted.
      @(negedge clk);
      rst_i   = 1'b1;
      valid_i = 1'b1;
      @(negedge clk);
      chk("rstvalid_outs", 32'({ready_o, done_o, sclk_o, sync_n_o, sdin_o}), 32'b10110);
      rst_i   = 1'b0;
      valid_i = 1'b0;
      @(negedge clk);
      chk("rstvalid_idle", 32'({ready_o, sync_n_o}), 32'b11);

      // Random frames.
      for (int i = 0; i < 6; i++) begin
         d = 12'($urandom);
         p = 2'($urandom_range(0, 3));
         start_frame(d, p, 1'b0, ok);
         if (ok) run_frame(frame_word(d, p), 0, "rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
